// File: rtl/ring_token_arbiter.sv
// Round-robin token-ownership arbiter for one ring node shared by cache, messenger and locker.
// Optional owner-hold watchdog is compiled in with `define RING_ARB_WATCHDOG_EN.
module ring_token_arbiter #(
  parameter logic [3:0]  TOKEN_TYPE = 4'd1,
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] SlotTypeIn,
  input  logic [2:0] req,
  input  logic [2:0] rel,
  output logic [2:0] allow,
  output logic [2:0] waiting,
  output logic [2:0] owner,
  output logic       wdogErr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [2:0] owner_nxt;
  logic       tok;
  logic [2:0] pick;
  logic       rel_hit;
  logic       expire;

  // First requester at or after the priority pointer, wrapping 2 -> 0; pointer value 3 behaves as 0.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] g;
    g = 3'b000;
    case (p)
      2'd1: begin
        if      (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
        else if (r[0]) g = 3'b001;
      end
      2'd2: begin
        if      (r[2]) g = 3'b100;
        else if (r[0]) g = 3'b001;
        else if (r[1]) g = 3'b010;
      end
      default: begin
        if      (r[0]) g = 3'b001;
        else if (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  // Pointer value just past a one-hot owner, modulo 3.
  function automatic logic [1:0] ptr_after(input logic [2:0] oh);
    logic [1:0] p;
    case (oh)
      3'b001:  p = 2'd1;
      3'b010:  p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  assign tok     = (SlotTypeIn == TOKEN_TYPE);
  assign pick    = rr_pick(req, ptr);
  assign rel_hit = |(rel & owner);
  assign waiting = req & ~allow;

  // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    allow     = 3'b000;
    case (state)
      IDLE: begin
        allow = tok ? pick : 3'b000;
        if (tok && (|req)) begin
          owner_nxt = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // The owner keeps its qualifier for the whole tenure, so its burst logic is never cut off.
        allow = owner;
        if (rel_hit || expire) begin
          owner_nxt = 3'b000;
          ptr_nxt   = ptr_after(owner);
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = 3'b000;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 3'b000;
      ptr   <= 2'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

`ifdef RING_ARB_WATCHDOG_EN
  localparam int unsigned CW = $clog2(WDOG_LIMIT + 1);

  logic [CW-1:0] wdog_cnt, wdog_cnt_nxt;
  logic          err_nxt;

  // Counter holds the number of completed BUSY cycles; the edge ending the LIMIT-th one forces release.
  assign expire = (state == BUSY) && (wdog_cnt == CW'(WDOG_LIMIT - 1));

  always_comb begin
    wdog_cnt_nxt = '0;
    err_nxt      = wdogErr;
    if (state == BUSY && !rel_hit && !expire) begin
      wdog_cnt_nxt = wdog_cnt + 1'b1;
    end
    if (expire && !rel_hit) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
      wdogErr  <= 1'b0;
    end else begin
      wdog_cnt <= wdog_cnt_nxt;
      wdogErr  <= err_nxt;
    end
  end
`else
  assign expire  = 1'b0;
  assign wdogErr = 1'b0;
`endif

endmodule

// File: doc/ring_token_arbiter.md
# ring_token_arbiter

Per-core arbiter for token ownership on the ring. Three local agents share one ring node: the data/instruction cache controller, the messenger and the locker. Each must capture the circulating Token slot before it drives Address/WriteData slots. The block picks one owner per token in round-robin order, holds that ownership until the owner releases, and gives each agent an `allow`/`waiting` qualifier to AND with its own "SlotTypeIn == Token" detection.

## Interface
- `TOKEN_TYPE`, 1: SlotTypeIn code of a Token slot.
- `WDOG_LIMIT`, 1023: maximum cycles an owner may hold the token (used only with the watchdog compiled in).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `SlotTypeIn`  in  4  slot type currently at this node's ring input.
- `req`  in  3  bit0 cache, bit1 messenger, bit2 locker; level, held high while the agent wants the token.
- `release`  in  3  one-cycle pulse from the owner when it has re-emitted the token.
- `allow`  out  3  combinational; agent i may consume a Token slot this cycle.
- `waiting`  out  3  combinational; `waiting[i] = req[i] & ~allow[i]`; drop-in replacement for msgrWaiting/lockerWaiting-style gating.
- `owner`  out  3  registered one-hot current owner; 0 when free.
- `wdogErr`  out  1  sticky; the watchdog has fired.

## Operation
- Round-robin pointer `ptr` (2 bits, values 0..2) names the highest-priority agent.
- States:
  - IDLE: `owner`=0. `tok = (SlotTypeIn == TOKEN_TYPE)`. `pick` = first set bit of `req`, scanning from `ptr` upward and wrapping 2→0. `allow = tok ? pick : 0`. If `tok & |req`: `owner <= pick`, go to BUSY. Otherwise stay.
  - BUSY: `allow = owner` regardless of slot type, so the owner keeps its burst/wait logic. On `release & owner` (the owner's own bit): `owner <= 0`, `ptr <= index(owner)+1 mod 3`, go to IDLE.
- Release pulses from non-owners, and any release in IDLE, are ignored.
- `req` deasserting while BUSY does not end ownership; only release (or the watchdog) does.
- The decision uses `req` as sampled in the token cycle. `req` changes in other cycles have no effect.
- Tokens that arrive in IDLE with `req == 0` pass untouched. No grant is made and the state does not change.

## Timing
- Grant is zero-latency: `allow` is valid in the same cycle the Token slot is present. `owner` reflects it from the next edge.
- Release cycle: `owner` is still set during the pulse and is 0 after the edge. The first token that can be granted to a new agent is the one seen in the cycle after the release.
- A token present in the same cycle as the release goes to the releasing owner only. Arbitration does not consider it.
- Reset values: `owner`=0, `ptr`=0, state IDLE, `wdogErr`=0, watchdog count 0. `allow`=0 and `waiting`=`req`, except that `allow` may go high in the first IDLE token cycle.
- Reset asserted mid-ownership clears everything immediately and asynchronously. Agents must abort on reset themselves.
- Pointer arithmetic is mod 3. The encoding 3 never occurs; if `ptr`==3 it is treated as 0.

## Configuration
- `RING_ARB_WATCHDOG_EN` defined:
  - A 10-bit (clog2 of WDOG_LIMIT+1) counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches `WDOG_LIMIT` without a release, the block forces a release: `owner` <= 0, `ptr` advances past the owner, `wdogErr` <= 1 (sticky until reset), go to IDLE.
  - A genuine release in the same cycle as expiry counts as normal; `wdogErr` is not set.
- Not defined: no counter; BUSY exits only by release; `wdogErr` tied 0.

## Test plan
- Only cache requests (`req`=001), Token at cycle 10 -> `allow`=001 at cycle 10, `owner`=001 from cycle 11. Release at 20 -> `owner`=0 at 21, `ptr`=1.
- `req`=111, three tokens each followed by release -> owners granted in order 001, 010, 100. A fourth token is granted to 001 again.
- While the messenger owns the token, Token slots arrive and the cache requests -> cache `allow`=0, `waiting[0]`=1. A release pulse from the cache or locker does not change `owner`.
- Release and Token in the same cycle with `req`=110 and owner=010 -> `allow`=010 that cycle, `owner`=0 next cycle. The next Token is granted to 100.
- With `RING_ARB_WATCHDOG_EN` and `WDOG_LIMIT`=8, owner 001 never releases -> `owner`=0 and `wdogErr`=1 after 8 BUSY cycles, `ptr`=1. Without the macro, `owner` stays 001 indefinitely.
- `reset` pulsed low while BUSY -> `owner`=0, `wdogErr`=0, `ptr`=0 immediately, without waiting for a clock edge. The next token with `req`=010 is granted to 010.
